sfx_scheduler: RTL and testbench

// Arbitrates game sound-effect requests (game over, line clear, piece lock, rotate) onto the single

---
 rtl/sfx_scheduler.sv | 150 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect arbiter and note sequencer driving a single square-wave
// tone generator; notes come from an internal ROM and are timed by a 1 ms tick.
module sfx_scheduler #(
  parameter int FCLK     = 50_000_000,
  parameter int TICK_DIV = FCLK / 1000,
  parameter int GAP_MS   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  sfx_req,
  input  logic        mute,
  output logic [15:0] freq,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [3:0]  sfx_done,
  output logic [3:0]  sfx_drop
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       active_id_q, note_idx_q, grant_id;
  logic [15:0]      freq_q, cnt_q;
  logic [3:0]       done_q, drop_q;
  logic             tick, grant_vld, preempt, take;

  function automatic logic [15:0] rom_freq(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: rom_freq = 16'd659;
      4'b00_01: rom_freq = 16'd523;
      4'b00_10: rom_freq = 16'd440;
      4'b01_00: rom_freq = 16'd523;
      4'b01_01: rom_freq = 16'd659;
      4'b01_10: rom_freq = 16'd784;
      4'b01_11: rom_freq = 16'd1047;
      4'b10_00: rom_freq = 16'd220;
      4'b11_00: rom_freq = 16'd880;
      default:  rom_freq = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] rom_dur(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00, 4'b00_01: rom_dur = 16'd300;
      4'b00_10:           rom_dur = 16'd600;
      4'b01_00, 4'b01_01,
      4'b01_10:           rom_dur = 16'd80;
      4'b01_11:           rom_dur = 16'd160;
      4'b10_00:           rom_dur = 16'd40;
      4'b11_00:           rom_dur = 16'd30;
      default:            rom_dur = 16'd1;
    endcase
  endfunction

  function automatic logic [1:0] rom_last(input logic [1:0] id);
    case (id)
      2'd0:    rom_last = 2'd2;
      2'd1:    rom_last = 2'd3;
      default: rom_last = 2'd0;
    endcase
  endfunction

  // Lowest pending index wins; a grant clears its bit even if re-requested this cycle.
  always_comb begin
    tick      = (div_q == DIV_W'(TICK_DIV - 1));
    grant_vld = |pending_q;
    grant_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) grant_id = 2'(i);
    end
    preempt   = (state_q != S_IDLE) && grant_vld && (grant_id < active_id_q);
    take      = preempt || ((state_q == S_IDLE) && grant_vld);
    pending_d = pending_q | sfx_req;
    if (take) pending_d[grant_id] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      pending_q   <= 4'd0;
      active_id_q <= 2'd0;
      note_idx_q  <= 2'd0;
      freq_q      <= 16'd0;
      cnt_q       <= 16'd0;
      done_q      <= 4'd0;
      drop_q      <= 4'd0;
    end else begin
      div_q     <= tick ? '0 : div_q + 1'b1;
      pending_q <= pending_d;
      done_q    <= 4'd0;
      drop_q    <= 4'd0;
      if (preempt) begin
        // In GAP the effect already completed, so it is not reported as dropped.
        if (state_q != S_GAP) drop_q[active_id_q] <= 1'b1;
        active_id_q <= grant_id;
        note_idx_q  <= 2'd0;
        state_q     <= S_LOAD;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (grant_vld) begin
              active_id_q <= grant_id;
              note_idx_q  <= 2'd0;
              state_q     <= S_LOAD;
            end
          end
          S_LOAD: begin
            freq_q  <= rom_freq(active_id_q, note_idx_q);
            cnt_q   <= rom_dur(active_id_q, note_idx_q);
            state_q <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              if (cnt_q <= 16'd1) begin
                if (note_idx_q == rom_last(active_id_q)) begin
                  done_q[active_id_q] <= 1'b1;
                  freq_q  <= 16'd0;
                  cnt_q   <= 16'(GAP_MS);
                  state_q <= S_GAP;
                end else begin
                  note_idx_q <= note_idx_q + 2'd1;
                  state_q    <= S_LOAD;
                end
              end else begin
                cnt_q <= cnt_q - 16'd1;
              end
            end
          end
          default: begin
            if (tick) begin
              if (cnt_q <= 16'd1) state_q <= S_IDLE;
              else cnt_q <= cnt_q - 16'd1;
            end
          end
        endcase
      end
    end
  end

  assign freq      = mute ? 16'd0 : freq_q;
  assign busy      = (state_q != S_IDLE);
  assign active_id = active_id_q;
  assign sfx_done  = done_q;
  assign sfx_drop  = drop_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: behavioural model of the effect scheduler checked every cycle,
// directed scenarios with hand-derived expectations, then randomized request traffic.
module tb_sfx_scheduler;
  localparam int TD  = 10;
  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sfx_req = 4'd0;
  logic        mute = 1'b0;
  logic [15:0] freq;
  logic        busy;
  logic [1:0]  active_id;
  logic [3:0]  sfx_done, sfx_drop;

  int n_checks = 0;
  int n_fail   = 0;

  sfx_scheduler #(.FCLK(10_000), .TICK_DIV(TD), .GAP_MS(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .sfx_req(sfx_req), .mute(mute),
    .freq(freq), .busy(busy), .active_id(active_id),
    .sfx_done(sfx_done), .sfx_drop(sfx_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Effect table: note frequencies, durations in ms, note counts.
  int ROM_F [4][4] = '{'{659, 523, 440, 0}, '{523, 659, 784, 1047}, '{220, 0, 0, 0}, '{880, 0, 0, 0}};
  int ROM_D [4][4] = '{'{300, 300, 600, 0}, '{80, 80, 80, 160}, '{40, 0, 0, 0}, '{30, 0, 0, 0}};
  int ROM_N [4]    = '{3, 4, 1, 1};

  // Model phases: 0 idle, 1 loading a note, 2 sounding a note, 3 trailing silence.
  int         m_phase = 0, m_id = 0, m_note = 0, m_left = 0, m_freq = 0, m_edge = 0;
  logic [3:0] m_pend = 4'd0, m_done = 4'd0, m_drop = 4'd0;
  int         g;
  logic [3:0] np;
  logic       tk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_id = 0; m_note = 0; m_left = 0; m_freq = 0; m_edge = 0;
      m_pend = 4'd0; m_done = 4'd0; m_drop = 4'd0;
    end else begin
      tk = ((m_edge % TD) == TD - 1);
      m_edge++;
      g = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
      np = m_pend | sfx_req;
      m_done = 4'd0;
      m_drop = 4'd0;
      if (m_phase != 0 && g >= 0 && g < m_id) begin
        if (m_phase != 3) m_drop[m_id] = 1'b1;
        np[g] = 1'b0; m_id = g; m_note = 0; m_phase = 1;
      end else if (m_phase == 0) begin
        if (g >= 0) begin np[g] = 1'b0; m_id = g; m_note = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        m_freq = ROM_F[m_id][m_note]; m_left = ROM_D[m_id][m_note]; m_phase = 2;
      end else if (m_phase == 2) begin
        if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_note == ROM_N[m_id] - 1) begin
              m_done[m_id] = 1'b1; m_freq = 0; m_left = GAP; m_phase = 3;
            end else begin
              m_note++; m_phase = 1;
            end
          end
        end
      end else if (tk) begin
        m_left--;
        if (m_left <= 0) m_phase = 0;
      end
      m_pend = np;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, v, lo, hi, $time);
    end
  endtask

  logic [26:0] cmp_a, cmp_e;
  always @(negedge clk) begin
    cmp_e = {(mute ? 16'd0 : m_freq[15:0]), (m_phase != 0),
             ((m_phase != 0) ? m_id[1:0] : 2'd0), m_done, m_drop};
    cmp_a = {freq, busy, ((m_phase != 0) ? active_id : 2'd0), sfx_done, sfx_drop};
    check("cycle {freq,busy,id,done,drop}", 32'(cmp_a), 32'(cmp_e));
  end

  task automatic pulse(input logic [3:0] v);
    @(posedge clk); #2; sfx_req = v;
    @(posedge clk); #2; sfx_req = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 20000) begin @(negedge clk); w++; end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_freq(input int f, input string name);
    int w = 0;
    while (freq != 16'(f) && w < 20000) begin @(negedge clk); w++; end
    check(name, 32'(freq), 32'(f));
  endtask

  task automatic measure(input int f, input int dur, input string name);
    int cyc = 0;
    wait_freq(f, {name, " start"});
    while (freq == 16'(f) && cyc < 20000) begin @(negedge clk); cyc++; end
    check_range({name, " length"}, cyc, dur * TD - TD, dur * TD + 1);
  endtask

  task automatic wait_done(input logic [3:0] mask, input string name, output logic [3:0] drops);
    int w = 0;
    drops = 4'd0;
    while (sfx_done == 4'd0 && w < 20000) begin @(negedge clk); drops |= sfx_drop; w++; end
    check(name, 32'(sfx_done), 32'(mask));
  endtask

  task automatic align();
    do begin @(posedge clk); #1; end while ((m_edge % TD) != 0);
  endtask

  logic [3:0] drops;
  int         lat1, lat2, sil;
  time        t0;
  logic       bad;

  initial begin
    // Reset state
    @(negedge clk);
    check("reset outputs", {freq, busy, active_id, sfx_done, sfx_drop}, 32'd0);
    @(posedge clk); #2; reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("idle after reset", 32'(busy), 32'd0);

    // 1: rotate from idle, sound on the third edge after sampling
    pulse(4'b1000);
    @(negedge clk); check("t1 freq edge1", 32'(freq), 32'd0);
    @(negedge clk); check("t1 busy edge2", {freq, busy}, 32'd1);
    @(negedge clk); check("t1 freq edge3", 32'(freq), 32'd880);
    measure(880, 30, "t1 rotate");
    check("t1 done", 32'(sfx_done), 32'b1000);
    wait_idle("t1 idle after gap");

    // 2: game over preempts line clear on its third note
    pulse(4'b0010);
    wait_freq(784, "t2 note2");
    pulse(4'b0001);
    @(negedge clk); check("t2 no drop yet", 32'(sfx_drop), 32'd0);
    @(negedge clk); check("t2 drop", 32'(sfx_drop), 32'b0010);
    measure(659, 300, "t2 n0");
    measure(523, 300, "t2 n1");
    measure(440, 600, "t2 n2");
    check("t2 done", 32'(sfx_done), 32'b0001);
    wait_idle("t2 idle");

    // 3: simultaneous lock and rotate
    pulse(4'b1100);
    measure(220, 40, "t3 lock");
    check("t3 done lock", 32'(sfx_done), 32'b0100);
    sil = 0;
    while (freq == 16'd0 && sil < 20000) begin @(negedge clk); sil++; end
    check_range("t3 gap length", sil, 195, 210);
    measure(880, 30, "t3 rotate");
    check("t3 done rotate", 32'(sfx_done), 32'b1000);
    wait_idle("t3 idle");

    // 4: lower-priority requests merge and wait
    pulse(4'b0001);
    wait_freq(659, "t4 start");
    pulse(4'b1000);
    repeat (50) @(negedge clk);
    pulse(4'b1000);
    wait_done(4'b0001, "t4 done game over", drops);
    check("t4 no drop", 32'(drops), 32'd0);
    measure(880, 30, "t4 rotate");
    check("t4 done rotate", 32'(sfx_done), 32'b1000);
    wait_idle("t4 idle");
    bad = 1'b0;
    repeat (500) begin @(negedge clk); if (busy || freq != 16'd0) bad = 1'b1; end
    check("t4 rotate once", 32'(bad), 32'd0);

    // 5: mute leaves timing untouched
    align();
    pulse(4'b0010);
    t0 = $time;
    wait_done(4'b0010, "t5 done unmuted", drops);
    lat1 = int'(($time - t0) / 10);
    wait_idle("t5 idle a");
    align();
    pulse(4'b0010);
    t0 = $time;
    wait_freq(659, "t5 note1");
    @(posedge clk); #2; mute = 1'b1;
    @(negedge clk);
    check("t5 muted freq", 32'(freq), 32'd0);
    check("t5 muted busy", 32'(busy), 32'd1);
    wait_done(4'b0010, "t5 done muted", drops);
    lat2 = int'(($time - t0) / 10);
    check("t5 done timing", 32'(lat2), 32'(lat1));
    check_range("t5 latency", lat1, 3990, 4030);
    mute = 1'b0;
    wait_idle("t5 idle b");

    // 6: reset mid-effect with a request still pending
    pulse(4'b0001);
    wait_freq(659, "t6 start");
    pulse(4'b1000);
    @(posedge clk); #2; reset_n = 1'b0;
    #1;
    check("t6 reset immediate", {freq, busy, sfx_done, sfx_drop}, 32'd0);
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b1;
    bad = 1'b0;
    repeat (1000) begin @(negedge clk); if (busy || freq != 16'd0) bad = 1'b1; end
    check("t6 silent after reset", 32'(bad), 32'd0);

    // Randomized traffic, mute toggles and occasional resets
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #2;
      sfx_req = 4'd0;
      if ($urandom_range(0, 3999) == 0) sfx_req[0] = 1'b1;
      for (int b = 1; b < 4; b++) if ($urandom_range(0, 119) == 0) sfx_req[b] = 1'b1;
      if ($urandom_range(0, 499) == 0) mute = ~mute;
      reset_n = ($urandom_range(0, 7999) == 0) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #2;
    sfx_req = 4'd0; mute = 1'b0; reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
